// File: rtl/layer_compositor.sv
// layer_compositor: N-layer priority compositor with 2-stage pipeline, frame-shadowed enables, optional COLLISION_DET_EN overlap counter
module layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 12,
  parameter int CNT_W      = 19
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          pixel_tick,
  input  logic [9:0]                    pixel_x,
  input  logic [9:0]                    pixel_y,
  input  logic                          video_on,
  input  logic                          hsync,
  input  logic                          vsync,
  input  logic [NUM_LAYERS-1:0]         layer_on,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [COLOR_W-1:0]            bg_rgb,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  output logic [COLOR_W-1:0]            rgb_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          video_on_out,
  output logic [NUM_LAYERS-1:0]         active_en,
  output logic [CNT_W-1:0]              collision_count,
  output logic                          collision_valid
);
  logic                          frame_start;
  logic [NUM_LAYERS-1:0]         active_en_q, active_en_d;
  logic [NUM_LAYERS-1:0]         eff_on_q, eff_on_d;
  logic [NUM_LAYERS*COLOR_W-1:0] rgb_s1_q, rgb_s1_d;
  logic [COLOR_W-1:0]            bg_s1_q, bg_s1_d;
  logic [2:0]                    ctl_s1_q, ctl_s1_d;
  logic [2:0]                    ctl_s2_q, ctl_s2_d;
  logic [COLOR_W-1:0]            rgb_out_q, rgb_out_d;
  logic [COLOR_W-1:0]            pick;

  always_comb begin
    frame_start = pixel_tick && pixel_x == '0 && pixel_y == '0;
    active_en_d = frame_start ? layer_en : active_en_q;
    eff_on_d    = pixel_tick ? (layer_on & active_en_q) : eff_on_q;
    rgb_s1_d    = pixel_tick ? layer_rgb : rgb_s1_q;
    bg_s1_d     = pixel_tick ? bg_rgb : bg_s1_q;
    ctl_s1_d    = pixel_tick ? {video_on, hsync, vsync} : ctl_s1_q;
    ctl_s2_d    = pixel_tick ? ctl_s1_q : ctl_s2_q;
    pick        = bg_s1_q;
    // scan from lowest priority upward so the lowest set index wins
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (eff_on_q[i]) pick = rgb_s1_q[i*COLOR_W +: COLOR_W];
    rgb_out_d   = pixel_tick ? (ctl_s1_q[2] ? pick : '0) : rgb_out_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_en_q <= '1;
      eff_on_q    <= '0;
      rgb_s1_q    <= '0;
      bg_s1_q     <= '0;
      ctl_s1_q    <= '0;
      ctl_s2_q    <= '0;
      rgb_out_q   <= '0;
    end else begin
      active_en_q <= active_en_d;
      eff_on_q    <= eff_on_d;
      rgb_s1_q    <= rgb_s1_d;
      bg_s1_q     <= bg_s1_d;
      ctl_s1_q    <= ctl_s1_d;
      ctl_s2_q    <= ctl_s2_d;
      rgb_out_q   <= rgb_out_d;
    end
  end

  assign rgb_out      = rgb_out_q;
  assign video_on_out = ctl_s2_q[2];
  assign hsync_out    = ctl_s2_q[1];
  assign vsync_out    = ctl_s2_q[0];
  assign active_en    = active_en_q;

`ifdef COLLISION_DET_EN
  logic             hit;
  logic [CNT_W-1:0] run_q, run_d, cnt_q, cnt_d;
  logic             valid_q, valid_d;

  always_comb begin
    hit     = video_on & layer_on[0] & layer_on[1] & active_en_q[0] & active_en_q[1];
    cnt_d   = frame_start ? run_q : cnt_q;
    valid_d = frame_start;
    // frame-start pixel seeds the new frame's count; otherwise saturate
    run_d   = frame_start ? CNT_W'(hit) :
              (pixel_tick && hit && run_q != '1) ? run_q + 1'b1 : run_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign collision_count = cnt_q;
  assign collision_valid = valid_q;
`else
  assign collision_count = '0;
  assign collision_valid = 1'b0;
`endif
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: randomized bench for layer_compositor against a per-pixel reference model
module tb_layer_compositor;
  localparam int N = 4, C = 12, CW = 19, FW = 120, FH = 60;

  logic clk = 1'b0, reset_n = 1'b0, pixel_tick = 1'b0;
  logic video_on = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic [N-1:0] layer_on = '0, layer_en = '1;
  logic [N*C-1:0] layer_rgb = '0;
  logic [C-1:0] bg_rgb = '0;
  logic [C-1:0] rgb_out;
  logic hsync_out, vsync_out, video_on_out, collision_valid;
  logic [N-1:0] active_en;
  logic [CW-1:0] collision_count;

  always #5 clk = ~clk;

  layer_compositor #(.NUM_LAYERS(N), .COLOR_W(C), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .layer_on(layer_on), .layer_rgb(layer_rgb),
    .bg_rgb(bg_rgb), .layer_en(layer_en), .rgb_out(rgb_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .video_on_out(video_on_out),
    .active_en(active_en), .collision_count(collision_count),
    .collision_valid(collision_valid)
  );

  typedef struct packed {
    logic [C-1:0] rgb;
    logic hs, vs, vid;
  } pix_t;

  pix_t pq[$];
  pix_t cur;
  logic [N-1:0] m_en, en_cur;
  longint m_run, m_cnt;
  logic m_valid;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*C-1:0] rand_rgb();
    logic [N*C-1:0] r;
    for (int i = 0; i < N; i++) r[i*C +: C] = C'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    pq.delete();
    pq.push_back('0);
    cur = '0;
    m_en = '1;
    m_run = 0;
    m_cnt = 0;
    m_valid = 1'b0;
  endtask

  task automatic check_all();
    chk("rgb_out", 32'(rgb_out), 32'(cur.rgb));
    chk("hsync_out", 32'(hsync_out), 32'(cur.hs));
    chk("vsync_out", 32'(vsync_out), 32'(cur.vs));
    chk("video_on_out", 32'(video_on_out), 32'(cur.vid));
    chk("active_en", 32'(active_en), 32'(m_en));
`ifdef COLLISION_DET_EN
    chk("coll_valid", 32'(collision_valid), 32'(m_valid));
    chk("coll_count", 32'(collision_count), 32'(m_cnt));
`else
    chk("coll_valid", 32'(collision_valid), 32'd0);
    chk("coll_count", 32'(collision_count), 32'd0);
`endif
  endtask

  task automatic apply(input int x, input int y, input logic vid, input logic hs, input logic vs,
                       input logic [N-1:0] on, input logic [N-1:0] en,
                       input logic [N*C-1:0] rgb, input logic [C-1:0] bg);
    pix_t p;
    logic [N-1:0] eff;
    bit hit;
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = vid; hsync = hs; vsync = vs;
    layer_on = on; layer_en = en; layer_rgb = rgb; bg_rgb = bg; pixel_tick = 1'b1;
    @(posedge clk);
    #1 pixel_tick = 1'b0;
    eff = on & m_en;
    p.vid = vid; p.hs = hs; p.vs = vs; p.rgb = bg;
    if (!vid) p.rgb = '0;
    else
      for (int i = 0; i < N; i++)
        if (eff[i]) begin
          p.rgb = rgb[i*C +: C];
          break;
        end
    hit = vid && on[0] && on[1] && m_en[0] && m_en[1];
    if (x == 0 && y == 0) begin
      m_cnt = m_run; m_valid = 1'b1; m_run = hit ? 1 : 0; m_en = en;
    end else begin
      m_valid = 1'b0;
      if (hit && m_run < (64'd1 << CW) - 1) m_run++;
    end
    pq.push_back(p);
    cur = pq.pop_front();
    check_all();
  endtask

  task automatic stall();
    pixel_tick = 1'b0;
    pixel_x = ($urandom % 2) ? 10'd0 : 10'($urandom);
    pixel_y = ($urandom % 2) ? 10'd0 : 10'($urandom);
    video_on = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
    layer_on = N'($urandom); layer_en = N'($urandom); layer_rgb = rand_rgb(); bg_rgb = C'($urandom);
    @(posedge clk);
    #1 m_valid = 1'b0;
    check_all();
  endtask

  task automatic run_frame(input bit blk, input bit chg, input logic [N-1:0] new_en, input int start);
    logic [N-1:0] on;
    int x, y;
    for (int idx = start; idx < FW * FH; idx++) begin
      x = idx % FW;
      y = idx / FW;
      on = N'($urandom);
      if (blk && x >= 20 && x < 30 && y >= 10 && y < 20) on[1:0] = 2'b11;
      else if (on[1:0] == 2'b11) on[1] = 1'b0;
      if (chg && x == 100 && y == 50) en_cur = new_en;
      apply(x, y, x < 110, x >= 112 && x < 116, y == 58, on, en_cur, rand_rgb(), C'($urandom));
    end
  endtask

  initial begin
    logic [N*C-1:0] r;
    logic [C-1:0] bgv;
    model_reset();
    en_cur = '1;
    repeat (2) @(posedge clk);
    #1 check_all();
    reset_n = 1'b1;

    r = rand_rgb(); r[C +: C] = 12'hF00; r[2*C +: C] = 12'h0F0;
    bgv = 12'h35C;
    apply(5, 3, 1'b1, 1'b0, 1'b0, 4'b1110, en_cur, r, 12'h123);
    apply(6, 3, 1'b1, 1'b1, 1'b0, 4'b0000, en_cur, rand_rgb(), bgv);
    chk("prio_l1", 32'(rgb_out), 32'h F00);
    apply(7, 3, 1'b0, 1'b0, 1'b1, 4'b1111, en_cur, rand_rgb(), 12'h777);
    chk("bg_sel", 32'(rgb_out), 32'(bgv));
    chk("hs_lat2", 32'(hsync_out), 32'd1);
    apply(8, 3, 1'b1, 1'b0, 1'b0, 4'b0000, en_cur, rand_rgb(), 12'h111);
    chk("blank", 32'(rgb_out), 32'd0);
    chk("vs_lat2", 32'(vsync_out), 32'd1);

    run_frame(1'b1, 1'b1, 4'b1110, 0);
    r = rand_rgb(); r[0 +: C] = 12'hABC;
    apply(0, 0, 1'b1, 1'b0, 1'b0, 4'b0001, en_cur, r, 12'h222);
    chk("en_swap", 32'(active_en), 32'h E);
`ifdef COLLISION_DET_EN
    chk("cnt_100", 32'(collision_count), 32'd100);
    chk("vld_pulse", 32'(collision_valid), 32'd1);
`else
    chk("cnt_off", 32'(collision_count), 32'd0);
    chk("vld_off", 32'(collision_valid), 32'd0);
`endif
    r = rand_rgb(); r[0 +: C] = 12'h5A5;
    apply(1, 0, 1'b1, 1'b0, 1'b0, 4'b0001, en_cur, r, 12'h0AA);
    chk("old_mask_px0", 32'(rgb_out), 32'h ABC);
    chk("vld_one_clk", 32'(collision_valid), 32'd0);
    apply(2, 0, 1'b1, 1'b0, 1'b0, 4'b0001, en_cur, rand_rgb(), 12'h333);
    chk("l0_masked", 32'(rgb_out), 32'h 0AA);
    run_frame(1'b1, 1'b1, N'($urandom), 3);
    run_frame(1'b0, 1'b0, '0, 0);

    for (int x = 298; x <= 300; x++)
      apply(x, 200, 1'b1, 1'($urandom), 1'($urandom), N'($urandom), en_cur, rand_rgb(), C'($urandom));
    #3 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      apply(10 + k, 7, 1'b1, 1'($urandom), 1'($urandom), N'($urandom), N'($urandom), rand_rgb(), C'($urandom));
      repeat (3) stall();
    end

    for (int k = 0; k < 400; k++) begin
      if ($urandom % 20 == 0)
        apply(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), N'($urandom), N'($urandom), rand_rgb(), C'($urandom));
      else
        apply(int'($urandom % 640), int'($urandom % 480), 1'($urandom), 1'($urandom), 1'($urandom),
              N'($urandom), N'($urandom), rand_rgb(), C'($urandom));
      if ($urandom % 4 == 0) stall();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
